jpeg_pix_pack: RTL
==================

JPEG_PIX_PACK -- requirements
Module: jpeg_pix_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter CNT_W, default 24, width of the per-frame pixel counter.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pix_we  in  1  pixel strobe from the decoder top (bo_we).
REQ-006 SHALL have port pix_begin  in  1  first pixel of frame (bo_begin), qualified by pix_we.
REQ-007 SHALL have port pix_end  in  1  last pixel of frame (bo_end), qualified by pix_we.
REQ-008 SHALL have port pix_data  in  32  {r,g,b,8'h00} (bo_data).
REQ-009 SHALL have port pix_next  out  1  request to the decoder (drives bi_next).
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_data out 32, out_first out 1, out_last out 1, out_half out 1: downstream stream.
REQ-011 SHALL have ports frame_cnt out CNT_W (pixels in the last completed frame), ovf_err out 1, seq_err out 1 (sticky).

Function
REQ-012 SHALL accept a pixel on every cycle with pix_we=1 and write it into the FIFO.
REQ-013 SHALL assert pix_next only while free FIFO entries >= 2, covering one in-flight pixel.
REQ-014 SHALL drop a pixel arriving with the FIFO full and set ovf_err; a simultaneous pop frees the slot first, so there is no overflow.
REQ-015 SHALL run the FSM IDLE -> RUN on a popped begin pixel, RUN -> FLUSH on a popped end pixel, and FLUSH -> IDLE when the final word is accepted.
REQ-016 SHALL discard pixels popped in IDLE without a begin, set seq_err, and keep the FSM in IDLE.
REQ-017 SHALL handle a begin pixel popped in RUN as follows: set seq_err, drop any held half-word, and restart the frame with that pixel.
REQ-018 SHALL convert each pixel to RGB565: {r[7:3],g[7:2],b[7:3]}.
REQ-019 SHALL pack two pixels per word, with the earlier pixel in out_data[31:16].
REQ-020 SHALL, on an odd pixel count at end, emit the last word with [15:0]=0 and out_half=1; otherwise out_half=0.
REQ-021 SHALL set out_first on the word holding the frame's first pixel and out_last on the word holding its end pixel; a one-pixel frame sets both.
REQ-022 SHALL hold out_valid and all out_* stable until out_ready=1 (AXI-style; no combinational path from out_ready to out_valid).
REQ-023 SHALL produce out_valid no earlier than 2 cycles after the pix_we of the word's last pixel, with sustained throughput of 1 word per 2 pixels.
REQ-024 SHALL load frame_cnt on acceptance of the last word; the counter saturates at all-ones.
REQ-025 SHALL clear the internal pixel counter on each begin.

Reset
REQ-026 SHALL, while rst=0, force pix_next=0, out_valid=0, out_data=0, out_first=out_last=out_half=0, frame_cnt=0, ovf_err=seq_err=0, FIFO empty, and FSM IDLE.
REQ-027 SHALL treat reset mid-frame as abandoning the frame silently, with no out_last emitted.
REQ-028 SHALL assert pix_next on the first edge after rst deasserts.

Configuration
REQ-029 SHALL, with JPEG_RGB565_PACK_EN defined, behave as REQ-018..REQ-020.
REQ-030 SHALL, with JPEG_RGB565_PACK_EN undefined, emit one pixel per word unmodified (out_data=pix_data), with out_half always 0 and throughput 1 word per pixel.

Structure
REQ-031 SHALL take FSM state encodings and the RGB565 field-position constants from jpeg_defines.v.
REQ-032 SHALL implement the FIFO as sub-module jpeg_pix_fifo (synchronous, registered count, full/empty/free outputs).

Verification
REQ-033 SHALL cover a 4-pixel frame, pixels 0xFF000000, 0x00FF0000, 0x0000FF00, 0xFFFFFF00 with out_ready=1: expect words 0xF80007E0 (first) and 0x001FFFFF (last), then frame_cnt=4.
REQ-034 SHALL cover a 3-pixel frame: expect 2 words, the second with out_half=1 and [15:0]=0x0000.
REQ-035 SHALL cover a 256-pixel frame (pic_is_411 size) with out_ready low for 40 cycles: expect pix_next to fall and no ovf_err, 128 words, and frame_cnt=256.
REQ-036 SHALL cover a forced pix_we with FIFO full and no pop: expect ovf_err=1 and the frame short by one pixel.
REQ-037 SHALL cover pixels before any begin, then a begin mid-frame: expect seq_err=1 and output restarting with out_first at the new begin.
REQ-038 SHALL cover rst pulsed low mid-frame: expect all outputs at reset values, then a clean subsequent frame.

Source files
------------

// File: rtl/jpeg_pix_pack_pkg.sv
// Shared types for the JPEG pixel packer: FSM states, FIFO entry layout and RGB565 field positions.
package jpeg_pix_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Source bit ranges of the RGB565 fields inside a {r,g,b,8'h00} pixel.
    localparam int R_MSB = 31;
    localparam int R_LSB = 27;
    localparam int G_MSB = 23;
    localparam int G_LSB = 18;
    localparam int B_MSB = 15;
    localparam int B_LSB = 11;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] data;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

    function automatic logic [15:0] to_rgb565(input logic [31:0] p);
        return {p[R_MSB:R_LSB], p[G_MSB:G_LSB], p[B_MSB:B_LSB]};
    endfunction

endpackage

// File: rtl/jpeg_pix_fifo.sv
// Synchronous pixel FIFO with a registered occupancy count; a pop in the same cycle frees a slot for a push.
module jpeg_pix_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 34,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign free    = (AW+1)'(DEPTH) - count;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need one, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_pix_pack.sv
// Buffers decoder pixels and emits them as a ready/valid word stream with frame markers.
// Define JPEG_RGB565_PACK_EN to pack two RGB565 pixels per word; otherwise pixels pass through 1:1.
module jpeg_pix_pack
    import jpeg_pix_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_we,
    input  logic             pix_begin,
    input  logic             pix_end,
    input  logic [31:0]      pix_data,
    output logic             pix_next,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             out_half,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             ovf_err,
    output logic             seq_err
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FREE_MIN = (AW+1)'(2);

    state_t           state, state_nxt;
    logic             alive_q;
    logic             fifo_full, fifo_empty, pop;
    logic [AW:0]      fifo_free;
    logic [PIX_W-1:0] fifo_rd;
    pix_t             in_pix, head;
    logic [CNT_W-1:0] pix_cnt;
    logic             emit, word_first, word_last, word_half;
    logic [31:0]      word_data;
    logic             cnt_clr, cnt_inc, seq_set;
`ifdef JPEG_RGB565_PACK_EN
    logic [15:0]      half_q, rgb;
    logic             half_v, half_first, hold, hold_clr;

    assign rgb = to_rgb565(head.data);
`endif

    assign in_pix   = '{first: pix_begin, last: pix_end, data: pix_data};
    assign head     = pix_t'(fifo_rd);
    // Two free slots leave room for the pixel already in flight when pix_next drops.
    assign pix_next = alive_q && (fifo_free >= FREE_MIN);

    jpeg_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pix_we),
        .wr_data (in_pix),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        emit       = 1'b0;
        word_data  = '0;
        word_first = 1'b0;
        word_last  = 1'b0;
        word_half  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        seq_set    = 1'b0;
`ifdef JPEG_RGB565_PACK_EN
        hold       = 1'b0;
        hold_clr   = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_RUN: begin
                // Pop only when the output slot is free, so a held word never changes.
                if (!fifo_empty && (!out_valid || out_ready)) begin
                    pop = 1'b1;
                    if (!head.first && state == ST_IDLE) begin
                        seq_set = 1'b1;
                    end else begin
                        seq_set   = head.first && (state == ST_RUN);
                        cnt_clr   = head.first;
                        cnt_inc   = !head.first;
                        state_nxt = head.last ? ST_FLUSH : ST_RUN;
`ifdef JPEG_RGB565_PACK_EN
                        if (half_v && !head.first) begin
                            emit       = 1'b1;
                            word_data  = {half_q, rgb};
                            word_first = half_first;
                            word_last  = head.last;
                            hold_clr   = 1'b1;
                        end else if (head.last) begin
                            emit       = 1'b1;
                            word_data  = {rgb, 16'h0000};
                            word_first = head.first;
                            word_last  = 1'b1;
                            word_half  = 1'b1;
                            hold_clr   = 1'b1;
                        end else begin
                            hold = 1'b1;
                        end
`else
                        emit       = 1'b1;
                        word_data  = head.data;
                        word_first = head.first;
                        word_last  = head.last;
`endif
                    end
                end
            end
            ST_FLUSH: begin
                if (out_valid && out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_half  <= 1'b0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            ovf_err   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= word_data;
                out_first <= word_first;
                out_last  <= word_last;
                out_half  <= word_half;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cnt_clr) begin
                pix_cnt <= CNT_W'(1);
            end else if (cnt_inc && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (out_valid && out_ready && out_last) frame_cnt <= pix_cnt;
            if (pix_we && fifo_full && !pop)        ovf_err   <= 1'b1;
            if (seq_set)                            seq_err   <= 1'b1;
        end
    end

`ifdef JPEG_RGB565_PACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_q     <= '0;
            half_v     <= 1'b0;
            half_first <= 1'b0;
        end else if (hold) begin
            half_q     <= rgb;
            half_v     <= 1'b1;
            half_first <= head.first;
        end else if (hold_clr) begin
            half_v     <= 1'b0;
        end
    end
`endif

endmodule
